// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory request queue: op encoding,
// queue entry layout, kseg translation and store lane alignment.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7,
        OP_SWL = 4'd8,
        OP_SWR = 4'd9
    } mem_op_t;

    localparam logic [31:0] KSEG0_BASE     = 32'h8000_0000;
    localparam logic [31:0] KSEG1_END      = 32'hBFFF_FFFF;
    localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Strobes and data for one 32-bit word; 64-bit placement happens at issue.
    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] data;
    } lane_t;

    // Queue entry. Only the word address is kept: the bus address has its
    // low bits forced to zero, and bit 0 of waddr picks the half on a
    // 64-bit bus.
    typedef struct packed {
        logic        wr;
        logic [29:0] waddr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic op_is_store(mem_op_t op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // SWL/SWR are partial word writes described entirely by their strobes.
    function automatic logic [1:0] op_size(mem_op_t op);
        logic [1:0] r;
        case (op)
            OP_LB, OP_LBU, OP_SB: r = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: r = SIZE_HALF;
            default:              r = SIZE_WORD;
        endcase
        return r;
    endfunction

    function automatic logic op_misaligned(mem_op_t op, logic [1:0] ofs);
        logic r;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = ofs[0];
            OP_LW, OP_SW:         r = |ofs;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] kseg_translate(logic [31:0] va, logic en);
        logic [31:0] r;
        if (en && (va >= KSEG0_BASE) && (va <= KSEG1_END)) begin
            r = va & KSEG_PHYS_MASK;
        end else begin
            r = va;
        end
        return r;
    endfunction

    // Little-endian lane placement within a word; loads get no strobes.
    function automatic lane_t lane_align(mem_op_t op, logic [1:0] ofs, logic [31:0] rt);
        lane_t r;
        r.strb = 4'b0000;
        r.data = 32'h0;
        case (op)
            OP_SB: begin
                r.strb = 4'b0001 << ofs;
                r.data = {24'h0, rt[7:0]} << {ofs, 3'b000};
            end
            OP_SH: begin
                r.strb = 4'b0011 << ofs;
                r.data = {16'h0, rt[15:0]} << {ofs, 3'b000};
            end
            OP_SW: begin
                r.strb = 4'b1111;
                r.data = rt;
            end
            OP_SWL: begin
                // 3 - ofs == ~ofs for a 2-bit offset
                r.strb = 4'b1111 >> (~ofs);
                r.data = rt >> {~ofs, 3'b000};
            end
            OP_SWR: begin
                r.strb = 4'b1111 << ofs;
                r.data = rt << {ofs, 3'b000};
            end
            default: begin
                r.strb = 4'b0000;
                r.data = 32'h0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with occupancy count and a flush that can optionally keep
// the current head entry alive.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         keep_head,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Entry storage; writes are dropped during flush so no stale entry lands.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and count; flush either empties or collapses to the head only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            if (keep_head && !empty) begin
                wr_ptr <= rd_ptr + PTR_W'(1);
                count  <= CNT_W'(1);
            end else begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// Execute-side memory request queue: alignment check with AdEL/AdES
// reporting, kseg translation, lane alignment, and an in-order FIFO issuing
// on a valid/ready port toward the cache/AXI bridge.
module mem_req_queue
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int KSEG_MAP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  mem_op_t                      in_op,
    input  logic [31:0]                  in_addr,
    input  logic [31:0]                  in_wdata,
    input  logic                         flush,
    output logic                         exc_valid,
    output logic                         exc_ades,
    output logic [31:0]                  exc_badvaddr,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic                         req_wr,
    output logic [31:0]                  req_addr,
    output logic [1:0]                   req_size,
    output logic [DATA_W/8-1:0]          req_wstrb,
    output logic [DATA_W-1:0]            req_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int REQ_W = $bits(mem_req_t);

    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        misaligned;
    logic        enq;
    logic        deq;
    logic        keep_head;
    logic [31:0] paddr;
    lane_t       lane;
    mem_req_t    enq_req;
    mem_req_t    head_req;

    // in_ready also drops combinationally with rst so EXE never sees a
    // ready queue while it is being cleared.
    assign in_ready   = !rst && !fifo_full && !flush;
    assign accept     = in_valid && in_ready;
    assign misaligned = op_misaligned(in_op, in_addr[1:0]);
    assign enq        = accept && !misaligned;

    assign req_valid  = !fifo_empty;
    assign deq        = req_valid && req_ready;
    // A head already on the port without ready must finish its handshake,
    // so it survives the flush.
    assign keep_head  = flush && req_valid && !req_ready;

    assign paddr = kseg_translate(in_addr, KSEG_MAP != 0);
    assign lane  = lane_align(in_op, paddr[1:0], in_wdata);

    // Pack the translated, lane-aligned request into a queue entry.
    always_comb begin
        enq_req       = '0;
        enq_req.wr    = op_is_store(in_op);
        enq_req.waddr = paddr[31:2];
        enq_req.size  = op_size(in_op);
        enq_req.wstrb = lane.strb;
        enq_req.wdata = lane.data;
    end

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (enq),
        .wr_data   (enq_req),
        .rd_en     (deq),
        .flush     (flush),
        .keep_head (keep_head),
        .rd_data   (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Address-error pulse, one cycle after the faulting op is accepted;
    // flush does not cancel a pulse that is already registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_valid    <= 1'b0;
            exc_ades     <= 1'b0;
            exc_badvaddr <= 32'h0;
        end else begin
            exc_valid <= accept && misaligned;
            if (accept && misaligned) begin
                exc_ades     <= op_is_store(in_op);
                exc_badvaddr <= in_addr;
            end
        end
    end

    assign req_wr   = head_req.wr;
    assign req_size = head_req.size;

    // Bus-width specific placement of the stored word.
    if (DATA_W == 64) begin : g_bus64
        assign req_addr  = {head_req.waddr[29:1], 3'b000};
        assign req_wstrb = head_req.waddr[0] ? {head_req.wstrb, 4'b0000}
                                             : {4'b0000, head_req.wstrb};
        assign req_wdata = head_req.waddr[0] ? {head_req.wdata, 32'h0}
                                             : {32'h0, head_req.wdata};
    end else begin : g_bus32
        assign req_addr  = {head_req.waddr, 2'b00};
        assign req_wstrb = head_req.wstrb;
        assign req_wdata = head_req.wdata;
    end

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    mem_op_t     in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        exc_valid;
    logic        exc_ades;
    logic [31:0] exc_badvaddr;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [2:0]  occupancy;

    logic        w_in_ready;
    logic        w_exc_valid;
    logic        w_exc_ades;
    logic [31:0] w_exc_badvaddr;
    logic        w_req_valid;
    logic        w_req_wr;
    logic [31:0] w_req_addr;
    logic [1:0]  w_req_size;
    logic [7:0]  w_req_wstrb;
    logic [63:0] w_req_wdata;
    logic [2:0]  w_occupancy;

    int errors = 0;
    int checks = 0;

    mem_req_queue #(.DATA_W(32), .DEPTH(4), .KSEG_MAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
        .exc_valid(exc_valid), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .occupancy(occupancy)
    );

    mem_req_queue #(.DATA_W(64), .DEPTH(4), .KSEG_MAP(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
        .exc_valid(w_exc_valid), .exc_ades(w_exc_ades), .exc_badvaddr(w_exc_badvaddr),
        .req_valid(w_req_valid), .req_ready(req_ready), .req_wr(w_req_wr),
        .req_addr(w_req_addr), .req_size(w_req_size), .req_wstrb(w_req_wstrb),
        .req_wdata(w_req_wdata), .occupancy(w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = a;
        in_wdata = d;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL rst_exc_valid: got %b want 0", exc_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_store_kseg;
        req_ready = 1'b1;
        drive(OP_SW, 32'h8000_1004, 32'hDEAD_BEEF);
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL sw_latency: got %b want 0", req_valid); end
        tick;
        idle;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b want 1", req_valid); end
        checks++; if (req_addr !== 32'h0000_1004) begin errors++; $display("FAIL sw_addr: got %h want 00001004", req_addr); end
        checks++; if (req_wstrb !== 4'hF) begin errors++; $display("FAIL sw_wstrb: got %h want f", req_wstrb); end
        checks++; if (req_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", req_wdata); end
        checks++; if (req_wr !== 1'b1) begin errors++; $display("FAIL sw_wr: got %b want 1", req_wr); end
        checks++; if (req_size !== 2'd2) begin errors++; $display("FAIL sw_size: got %0d want 2", req_size); end
        checks++; if (w_req_addr !== 32'h0000_1000) begin errors++; $display("FAIL sw64_addr: got %h want 00001000", w_req_addr); end
        checks++; if (w_req_wstrb !== 8'hF0) begin errors++; $display("FAIL sw64_wstrb: got %h want f0", w_req_wstrb); end
        checks++; if (w_req_wdata !== 64'hDEAD_BEEF_0000_0000) begin errors++; $display("FAIL sw64_wdata: got %h want deadbeef00000000", w_req_wdata); end
        tick;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL sw_drained: got %b want 0", req_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL sw_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_translate;
        req_ready = 1'b1;
        drive(OP_LW, 32'hA000_0010, 32'h1234_5678);
        tick;
        idle;
        checks++; if (req_addr !== 32'h0000_0010) begin errors++; $display("FAIL kseg1_addr: got %h want 00000010", req_addr); end
        checks++; if (req_wr !== 1'b0) begin errors++; $display("FAIL lw_wr: got %b want 0", req_wr); end
        checks++; if (req_wstrb !== 4'h0) begin errors++; $display("FAIL lw_wstrb: got %h want 0", req_wstrb); end
        tick;
        drive(OP_LBU, 32'hC000_0023, 32'hFFFF_FFFF);
        tick;
        idle;
        checks++; if (req_addr !== 32'hC000_0020) begin errors++; $display("FAIL kuseg_pass_addr: got %h want c0000020", req_addr); end
        checks++; if (req_size !== 2'd0) begin errors++; $display("FAIL lbu_size: got %0d want 0", req_size); end
        checks++; if (req_wdata !== 32'h0) begin errors++; $display("FAIL lbu_wdata: got %h want 0", req_wdata); end
        tick;
    endtask

    task automatic test_misaligned;
        req_ready = 1'b1;
        drive(OP_SH, 32'h0000_0003, 32'h0000_1234);
        tick;
        idle;
        checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL ades_valid: got %b want 1", exc_valid); end
        checks++; if (exc_ades !== 1'b1) begin errors++; $display("FAIL ades_flag: got %b want 1", exc_ades); end
        checks++; if (exc_badvaddr !== 32'h0000_0003) begin errors++; $display("FAIL ades_badvaddr: got %h want 00000003", exc_badvaddr); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL ades_occ: got %0d want 0", occupancy); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL ades_req_valid: got %b want 0", req_valid); end
        drive(OP_LW, 32'h8000_0002, 32'h0);
        tick;
        idle;
        checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL adel_valid: got %b want 1", exc_valid); end
        checks++; if (exc_ades !== 1'b0) begin errors++; $display("FAIL adel_flag: got %b want 0", exc_ades); end
        checks++; if (exc_badvaddr !== 32'h8000_0002) begin errors++; $display("FAIL adel_badvaddr: got %h want 80000002", exc_badvaddr); end
        tick;
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL exc_pulse_end: got %b want 0", exc_valid); end
    endtask

    task automatic test_sb_lanes;
        req_ready = 1'b1;
        drive(OP_SB, 32'h0000_0006, 32'h0000_00AB);
        tick;
        idle;
        checks++; if (req_wstrb !== 4'h4) begin errors++; $display("FAIL sb_wstrb: got %h want 4", req_wstrb); end
        checks++; if (req_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL sb_wdata: got %h want 00ab0000", req_wdata); end
        checks++; if (req_addr !== 32'h0000_0004) begin errors++; $display("FAIL sb_addr: got %h want 00000004", req_addr); end
        checks++; if (w_req_wstrb !== 8'h40) begin errors++; $display("FAIL sb64_wstrb: got %h want 40", w_req_wstrb); end
        checks++; if (w_req_wdata !== 64'h00AB_0000_0000_0000) begin errors++; $display("FAIL sb64_wdata: got %h want 00ab000000000000", w_req_wdata); end
        checks++; if (w_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL sb64_addr: got %h want 00000000", w_req_addr); end
        tick;
        drive(OP_SH, 32'h0000_0002, 32'h5555_CAFE);
        tick;
        idle;
        checks++; if (req_wstrb !== 4'hC) begin errors++; $display("FAIL sh_wstrb: got %h want c", req_wstrb); end
        checks++; if (req_wdata !== 32'hCAFE_0000) begin errors++; $display("FAIL sh_wdata: got %h want cafe0000", req_wdata); end
        checks++; if (req_size !== 2'd1) begin errors++; $display("FAIL sh_size: got %0d want 1", req_size); end
        checks++; if (w_req_wstrb !== 8'h0C) begin errors++; $display("FAIL sh64_wstrb: got %h want 0c", w_req_wstrb); end
        checks++; if (w_req_wdata !== 64'h0000_0000_CAFE_0000) begin errors++; $display("FAIL sh64_wdata: got %h want 00000000cafe0000", w_req_wdata); end
        tick;
    endtask

    task automatic test_back_to_back;
        req_ready = 1'b1;
        drive(OP_SWL, 32'h0000_0001, 32'h1122_3344);
        tick;
        drive(OP_SWR, 32'h0000_0002, 32'h1122_3344);
        checks++; if (req_wstrb !== 4'h3) begin errors++; $display("FAIL swl_wstrb: got %h want 3", req_wstrb); end
        checks++; if (req_wdata !== 32'h0000_1122) begin errors++; $display("FAIL swl_wdata: got %h want 00001122", req_wdata); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ1: got %0d want 1", occupancy); end
        tick;
        idle;
        checks++; if (req_wstrb !== 4'hC) begin errors++; $display("FAIL swr_wstrb: got %h want c", req_wstrb); end
        checks++; if (req_wdata !== 32'h3344_0000) begin errors++; $display("FAIL swr_wdata: got %h want 33440000", req_wdata); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ_same: got %0d want 1", occupancy); end
        tick;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", occupancy); end
    endtask

    task automatic test_full;
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_LW, 32'h0000_0100 + 32'(4 * i), 32'h0);
            tick;
        end
        drive(OP_LW, 32'h0000_0110, 32'h0);
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        tick;
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_held_occ: got %0d want 4", occupancy); end
        checks++; if (req_addr !== 32'h0000_0100) begin errors++; $display("FAIL full_head_stable: got %h want 00000100", req_addr); end
        req_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", in_ready); end
        tick;
        req_ready = 1'b0;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL full_after_hs_occ: got %0d want 3", occupancy); end
        checks++; if (req_addr !== 32'h0000_0104) begin errors++; $display("FAIL full_next_head: got %h want 00000104", req_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b want 1", in_ready); end
        tick;
        idle;
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_fifth_in: got %0d want 4", occupancy); end
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_0104 + 32'(4 * i)) begin
                errors++; $display("FAIL drain_order_%0d: got %b/%h want 1/%h", i, req_valid, req_addr, 32'h0000_0104 + 32'(4 * i));
            end
            tick;
        end
        checks++; if (req_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d want 0/0", req_valid, occupancy); end
        req_ready = 1'b0;
    endtask

    task automatic test_flush;
        req_ready = 1'b0;
        drive(OP_SW, 32'h0000_0200, 32'h0000_00A1);
        tick;
        drive(OP_SW, 32'h0000_0204, 32'h0000_00A2);
        tick;
        drive(OP_SW, 32'h0000_0208, 32'h0000_00A3);
        tick;
        drive(OP_LH, 32'h0000_0201, 32'h0);
        tick;
        idle;
        flush = 1'b1;
        #1;
        checks++; if (exc_valid !== 1'b1 || exc_ades !== 1'b0) begin errors++; $display("FAIL flush_exc_fires: got %b/%b want 1/0", exc_valid, exc_ades); end
        checks++; if (exc_badvaddr !== 32'h0000_0201) begin errors++; $display("FAIL flush_badvaddr: got %h want 00000201", exc_badvaddr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        checks++; if (occupancy !== 3'd3 || req_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_occ: got %0d/%b want 3/1", occupancy, req_valid); end
        tick;
        flush = 1'b0;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL flush_keep_occ: got %0d want 1", occupancy); end
        checks++; if (req_addr !== 32'h0000_0200 || req_wdata !== 32'h0000_00A1) begin errors++; $display("FAIL flush_keep_head: got %h/%h want 00000200/000000a1", req_addr, req_wdata); end
        checks++; if (w_occupancy !== 3'd1) begin errors++; $display("FAIL flush64_occ: got %0d want 1", w_occupancy); end
        req_ready = 1'b1;
        tick;
        checks++; if (req_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL flush_done: got %b/%0d want 0/0", req_valid, occupancy); end
        req_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        req_ready = 1'b0;
        drive(OP_LW, 32'h0000_0300, 32'h0);
        tick;
        drive(OP_LW, 32'h0000_0304, 32'h0);
        tick;
        idle;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL mid_occ: got %0d want 2", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL mid_rst_clear: got %b/%0d want 0/0", req_valid, occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_release: got %b/%b want 1/0", in_ready, req_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_LB;
        in_addr   = 32'h0;
        in_wdata  = 32'h0;
        flush     = 1'b0;
        req_ready = 1'b0;
        test_reset;
        test_store_kseg;
        test_translate;
        test_misaligned;
        test_sb_lanes;
        test_back_to_back;
        test_full;
        test_flush;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Parametrised successor to the execute-side memory pre-stage.
- Accepts one load/store request per cycle from EXE and checks alignment, raising AdEL/AdES.
- Maps kseg0/kseg1 addresses to physical, generates byte strobes and lane-aligned write data for a DATA_W-wide bus (SB/SH/SW/SWL/SWR).
- Buffers requests in a DEPTH-entry in-order FIFO and issues them on a valid/ready request port toward the cache/AXI bridge.
- Supports pipeline flush without breaking the request handshake.

Parameters:
- DATA_W, 32, bus data width; legal values 32 or 64.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- KSEG_MAP, 1, 1 = strip kseg0/kseg1 high bits; 0 = address passes through.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  EXE presents a memory op.
- in_ready  out  1  queue can accept.
- in_op  in  mem_op_t(4)  LB,LBU,LH,LHU,LW,SB,SH,SW,SWL,SWR.
- in_addr  in  32  virtual address.
- in_wdata  in  32  rt value.
- flush  in  1  exception/eret in MEM: discard queued requests.
- exc_valid  out  1  registered one-cycle address-error pulse.
- exc_ades  out  1  1 = store error, 0 = load error; valid with exc_valid.
- exc_badvaddr  out  32  faulting virtual address.
- req_valid  out  1  head request valid.
- req_ready  in  1  downstream accepts.
- req_wr  out  1  1 = store.
- req_addr  out  32  physical address, low log2(DATA_W/8) bits forced to 0.
- req_size  out  2  0 = byte, 1 = half, 2 = word.
- req_wstrb  out  DATA_W/8  byte enables; all 0 for loads.
- req_wdata  out  DATA_W  lane-aligned write data; unused lanes 0.
- occupancy  out  $clog2(DEPTH+1)  entries held.

Behaviour:
- Reset (async):
  - Outputs: in_ready=0 while rst is high and 1 afterwards; req_valid=0; exc_valid=0; occupancy=0.
  - State: head/tail pointers 0; presented flag 0.
- Accept:
  - in_ready = !full && !flush.
  - No same-cycle bypass when full, even if req_ready frees a slot.
- Alignment:
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - LB/LBU/SB/SWL/SWR are never misaligned.
  - A misaligned op that is accepted is NOT enqueued. Next cycle: exc_valid=1, exc_ades=store, exc_badvaddr=in_addr.
- Translation (KSEG_MAP=1):
  - 0x80000000–0xBFFFFFFF → addr & 0x1FFFFFFF.
  - All other addresses pass through unchanged.
- Lanes:
  - Lane index L = paddr[log2(DATA_W/8)-1:0].
  - SB: strobe bit L; data byte at lane L.
  - SH: strobes L, L+1.
  - SW: 4 strobes from L.
  - For DATA_W=64, the 32-bit half is selected by paddr[2].
  - SWL/SWR use little-endian MIPS semantics within the selected word, with o = addr[1:0]:
    - SWL writes bytes 0..o with rt[31:8(3-o)] right-justified.
    - SWR writes bytes o..3 with rt[31-8o:0] left-shifted by 8o.
- Latency: an entry enqueued in cycle N can assert req_valid no earlier than cycle N+1.
- Handshake:
  - Once req_valid rises, req_* stay stable until req_valid && req_ready.
  - The head dequeues on handshake.
- Flush:
  - All entries are discarded in the same cycle, except a head already presented (req_valid=1 in the flush cycle without req_ready). That head remains and completes its handshake.
  - occupancy becomes 0, or 1 if the presented head is kept.
  - An exc pulse that is already registered still fires.
- Simultaneous enqueue and dequeue: occupancy is unchanged; pointers wrap modulo DEPTH.
- Reset mid-transaction: everything is cleared immediately, including a presented head.

Decomposition:
- Shared package mem_pkg:
  - mem_op_t enum.
  - mem_req_t struct (wr, addr, size, wstrb, wdata).
  - KSEG0_BASE and KSEG1_END constants.
  - Function lane_align(op, addr, wdata) returning strobe and data.
- Sub-module sync_fifo #(WIDTH, DEPTH): storage, pointers and count. It supports a keep_head-flush input.

Test Plan:
- SW 0x80001004 data 0xDEADBEEF, req_ready=1 → next cycle req_addr=0x00001004, wstrb=4'hF, wdata=0xDEADBEEF, req_wr=1.
- SH to 0x00000003 → not enqueued; next cycle exc_valid=1, exc_ades=1, exc_badvaddr=0x00000003; occupancy stays 0.
- DATA_W=64, SB 0x00000006 data 0x000000AB → wstrb=8'h40, wdata=0x00AB_0000_0000_0000.
- SWL 0x00000001 rt=0x11223344 → wstrb=4'h3, wdata=0x00001122; SWR 0x00000002 same rt → wstrb=4'hC, wdata=0x33440000.
- req_ready=0, enqueue 4 loads → in_ready=0 at occupancy 4; the 5th request is held off until one handshake completes.
- Three entries queued, head presented with req_ready=0, flush=1 → occupancy=1; the head is unchanged and completes when req_ready=1; after that req_valid=0.
